// File: rtl/free_list_ctrl_pkg.sv
// Shared rename-stage types and free-list sizing.
package free_list_ctrl_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned FL_CAP    = NUM_PREGS - NUM_AREGS;
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
  localparam int unsigned PTR_W     = $clog2(FL_CAP);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;

  // Physical register index, shared with rename, dispatch and ROB payloads.
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [SUM_W-1:0]  sum_t;

endpackage

// File: rtl/free_list_ctrl_ram.sv
// Free-list storage: two show-ahead read ports, two write ports, reset-time
// load of the pregs that are not RAT-mapped out of reset.
module free_list_ctrl_ram
  import free_list_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  ptr_t  rd_addr_1_i,
  input  ptr_t  rd_addr_2_i,
  output preg_t rd_data_1_o,
  output preg_t rd_data_2_o,
  input  logic  we_1_i,
  input  ptr_t  wr_addr_1_i,
  input  preg_t wr_data_1_i,
  input  logic  we_2_i,
  input  ptr_t  wr_addr_2_i,
  input  preg_t wr_data_2_i
);

  preg_t mem_q [FL_CAP];

  // Entry i holds preg NUM_AREGS+i after reset; the two write addresses never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_CAP; i++) begin
        mem_q[i] <= PREG_W'(NUM_AREGS + i);
      end
    end else begin
      if (we_1_i) mem_q[wr_addr_1_i] <= wr_data_1_i;
      if (we_2_i) mem_q[wr_addr_2_i] <= wr_data_2_i;
    end
  end

  assign rd_data_1_o = mem_q[rd_addr_1_i];
  assign rd_data_2_o = mem_q[rd_addr_2_i];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list for the 2-wide rename stage: hands out up to two
// free pregs per cycle and reclaims up to two retired pregs per cycle.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  alloc_take_1,
  input  logic  alloc_take_2,
  output logic  alloc_valid_1,
  output logic  alloc_valid_2,
  output preg_t alloc_preg_1,
  output preg_t alloc_preg_2,
  input  logic  retire_flag_1,
  input  preg_t fp_ind_1,
  input  logic  retire_flag_2,
  input  preg_t fp_ind_2,
  output cnt_t  free_count,
  output logic  rename_stall,
  output logic  overflow_err,
  output logic  underflow_err
);

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic       pop_1, pop_2;
  logic       push_1, push_2;
  logic [1:0] n_pop, n_push;
  sum_t       room, room_after_1;
  ptr_t       wr_addr_2;

  // Accept logic: pops are judged on the registered count; pushes may use the
  // room freed by this cycle's accepted pops, slot 2 is the first to be dropped.
  always_comb begin
    pop_1        = alloc_take_1 & alloc_valid_1;
    pop_2        = alloc_take_1 & alloc_take_2 & alloc_valid_2;
    n_pop        = 2'(pop_1) + 2'(pop_2);
    room         = sum_t'(FL_CAP) - sum_t'(count_q) + sum_t'(n_pop);
    push_1       = retire_flag_1 & (room != '0);
    room_after_1 = room - sum_t'(push_1);
    push_2       = retire_flag_2 & (room_after_1 != '0);
    n_push       = 2'(push_1) + 2'(push_2);
    wr_addr_2    = tail_q + PTR_W'(push_1);

    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = CNT_W'(sum_t'(count_q) + sum_t'(n_push) - sum_t'(n_pop));
    unf_d   = unf_q | (alloc_take_1 & ~pop_1) | (alloc_take_2 & ~pop_2);
    ovf_d   = ovf_q | (retire_flag_1 & ~push_1) | (retire_flag_2 & ~push_2);
  end

  // Pointer, count and sticky error registers; reset drops any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(FL_CAP);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  free_list_ctrl_ram u_ram (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_1_i (head_q),
    .rd_addr_2_i (head_q + PTR_W'(1)),
    .rd_data_1_o (alloc_preg_1),
    .rd_data_2_o (alloc_preg_2),
    .we_1_i      (push_1),
    .wr_addr_1_i (tail_q),
    .wr_data_1_i (fp_ind_1),
    .we_2_i      (push_2),
    .wr_addr_2_i (wr_addr_2),
    .wr_data_2_i (fp_ind_2)
  );

  assign alloc_valid_1 = (count_q != '0);
  assign alloc_valid_2 = (count_q >= CNT_W'(2));
  assign free_count    = count_q;
  assign rename_stall  = (count_q < CNT_W'(2));
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Bench for free_list_ctrl: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_free_list_ctrl;
  import free_list_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  alloc_take_1, alloc_take_2;
  logic  alloc_valid_1, alloc_valid_2;
  preg_t alloc_preg_1, alloc_preg_2;
  logic  retire_flag_1, retire_flag_2;
  preg_t fp_ind_1, fp_ind_2;
  cnt_t  free_count;
  logic  rename_stall, overflow_err, underflow_err;

  always #5 clk = ~clk;

  free_list_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_take_1  (alloc_take_1),
    .alloc_take_2  (alloc_take_2),
    .alloc_valid_1 (alloc_valid_1),
    .alloc_valid_2 (alloc_valid_2),
    .alloc_preg_1  (alloc_preg_1),
    .alloc_preg_2  (alloc_preg_2),
    .retire_flag_1 (retire_flag_1),
    .fp_ind_1      (fp_ind_1),
    .retire_flag_2 (retire_flag_2),
    .fp_ind_2      (fp_ind_2),
    .free_count    (free_count),
    .rename_stall  (rename_stall),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rs, input bit t1, input bit t2,
                       input bit r1, input int f1, input bit r2, input int f2);
    rst           = rs;
    alloc_take_1  = t1;
    alloc_take_2  = t2;
    retire_flag_1 = r1;
    fp_ind_1      = PREG_W'(f1);
    retire_flag_2 = r2;
    fp_ind_2      = PREG_W'(f2);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, t1, t2, r1, r2;
    int f1, f2;
    int p1, p2, cnt;
    bit ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rs, input bit t1, input bit t2, input bit r1,
                              input int f1, input bit r2, input int f2,
                              input int p1, input int p2, input int cnt,
                              input bit ovf, input bit unf);
    vec_t v;
    v.rst = rs; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.f1 = f1; v.r2 = r2; v.f2 = f2;
    v.p1 = p1; v.p2 = p2; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int mq[$];
  bit m_ovf, m_unf;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < int'(FL_CAP); i++) mq.push_back(int'(NUM_AREGS) + i);
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_cycle(input bit rs, input bit t1, input bit t2,
                             input bit r1, input int f1, input bit r2, input int f2);
    int n;
    bit p1, p2;
    if (rs) begin
      model_reset();
      return;
    end
    n  = mq.size();
    p1 = t1 && n >= 1;
    p2 = t1 && t2 && n >= 2;
    if ((t1 && !p1) || (t2 && !p2)) m_unf = 1'b1;
    if (p1) void'(mq.pop_front());
    if (p2) void'(mq.pop_front());
    if (r1) begin
      if (mq.size() < int'(FL_CAP)) mq.push_back(f1 & 63);
      else m_ovf = 1'b1;
    end
    if (r2) begin
      if (mq.size() < int'(FL_CAP)) mq.push_back(f2 & 63);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_check(input string tag);
    int n;
    n = mq.size();
    chk({tag, " valid_1"}, 32'(alloc_valid_1), 32'(n >= 1));
    chk({tag, " valid_2"}, 32'(alloc_valid_2), 32'(n >= 2));
    if (n >= 1) chk({tag, " preg_1"}, 32'(alloc_preg_1), mq[0]);
    if (n >= 2) chk({tag, " preg_2"}, 32'(alloc_preg_2), mq[1]);
    chk({tag, " free_count"}, 32'(free_count), n);
    chk({tag, " rename_stall"}, 32'(rename_stall), 32'(n < 2));
    chk({tag, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
    chk({tag, " underflow_err"}, 32'(underflow_err), 32'(m_unf));
  endtask

  // One model-checked cycle: entered and left at a negedge.
  task automatic mstep(input string tag, input bit rs, input bit t1, input bit t2,
                       input bit r1, input int f1, input bit r2, input int f2);
    drive(rs, t1, t2, r1, f1, r2, f2);
    #1;
    model_check(tag);
    @(posedge clk);
    model_cycle(rs, t1, t2, r1, f1, r2, f2);
    @(negedge clk);
  endtask

  initial begin
    int  p1, p2;
    bit  heavy_push;
    bit  t1, t2, r1, r2, rs;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

    // Reset, then drain all 32 pregs two per cycle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32, 33, 32, 0, 0));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k, 0, 0));
    // From empty: two retires become visible only in the following cycle.
    tbl.push_back(mk(0, 0, 0, 1, 40, 1, 41, 40, 41, 2, 0, 0));
    // Down to one, then a double take consumes only the head.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 41, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Refill with pregs 0..31.
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0, 0, 0, 1, 2 * k - 2, 1, 2 * k - 1, 0, 1, 2 * k, 0, 1));
    // Full: pushes without pops dropped; with a double pop they are accepted.
    tbl.push_back(mk(0, 0, 0, 1, 5, 1, 6, 0, 1, 32, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 5, 1, 6, 2, 3, 32, 1, 1));
    for (int k = 1; k <= 15; k++) begin
      p1 = (k < 15) ? 2 + 2 * k : 5;
      p2 = (k < 15) ? 3 + 2 * k : 6;
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, p1, p2, 32 - 2 * k, 1, 1));
    end
    // Reset with traffic present discards that traffic.
    tbl.push_back(mk(1, 1, 1, 1, 7, 1, 8, 32, 33, 32, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].t1, tbl[i].t2, tbl[i].r1, tbl[i].f1, tbl[i].r2, tbl[i].f2);
      #1;
      if (i > 0) begin
        chk($sformatf("row%0d hold free_count", i), 32'(free_count), tbl[i-1].cnt);
        chk($sformatf("row%0d hold valid_1", i), 32'(alloc_valid_1), 32'(tbl[i-1].cnt >= 1));
        if (tbl[i-1].cnt >= 1)
          chk($sformatf("row%0d hold preg_1", i), 32'(alloc_preg_1), tbl[i-1].p1);
      end
      @(posedge clk);
      #1;
      chk($sformatf("row%0d free_count", i), 32'(free_count), tbl[i].cnt);
      chk($sformatf("row%0d valid_1", i), 32'(alloc_valid_1), 32'(tbl[i].cnt >= 1));
      chk($sformatf("row%0d valid_2", i), 32'(alloc_valid_2), 32'(tbl[i].cnt >= 2));
      chk($sformatf("row%0d rename_stall", i), 32'(rename_stall), 32'(tbl[i].cnt < 2));
      if (tbl[i].cnt >= 1) chk($sformatf("row%0d preg_1", i), 32'(alloc_preg_1), tbl[i].p1);
      if (tbl[i].cnt >= 2) chk($sformatf("row%0d preg_2", i), 32'(alloc_preg_2), tbl[i].p2);
      chk($sformatf("row%0d overflow_err", i), 32'(overflow_err), 32'(tbl[i].ovf));
      chk($sformatf("row%0d underflow_err", i), 32'(underflow_err), 32'(tbl[i].unf));
      @(negedge clk);
    end

    // Pointer wrap at constant occupancy, then reset mid-stream.
    model_reset();
    mstep("wrap_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 40; c++)
      mstep($sformatf("wrap%0d", c), 0, 1, 1, 1, $urandom_range(0, 63), 1, $urandom_range(0, 63));
    mstep("wrap_midrst", 1, 1, 1, 1, 9, 1, 10);

    // Randomized traffic alternating push-heavy and pop-heavy phases.
    heavy_push = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) heavy_push = ~heavy_push;
      rs = ($urandom_range(0, 299) == 0);
      t1 = heavy_push ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      t2 = t1 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      r1 = heavy_push ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r2 = $urandom_range(0, 1) == 1;
      mstep($sformatf("rnd%0d", c), rs, t1, t2, r1, $urandom_range(0, 63), r2,
            $urandom_range(0, 63));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    #1;
    model_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
